// File: rtl/shift_left.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : shift_left
// Description : Registered fixed-distance logical left shift with zero and
//               signed-overflow flags and a copy of the discarded top bits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module shift_left #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_value,
  output logic [WIDTH-1:0] shifted_value,
  output logic [SHIFT-1:0] shifted_out,
  output logic             zero,
  output logic             overflow
);

  localparam logic [SHIFT-1:0] c_fill = '0;

  logic [WIDTH-1-SHIFT:0] w_kept;
  logic [SHIFT:0]         w_top;
  logic [WIDTH-1:0]       w_shifted;
  logic                   w_zero;
  logic                   w_overflow;

  assign w_kept     = input_value[WIDTH-1-SHIFT:0];
  assign w_shifted  = {w_kept, c_fill};
  assign w_zero     = ~|w_kept;
  // Discarded bits plus the new sign bit must all match the old sign bit.
  assign w_top      = input_value[WIDTH-1:WIDTH-1-SHIFT];
  assign w_overflow = (|w_top) & ~(&w_top);

  always_ff @(posedge clk) begin
    if (rst) begin
      shifted_value <= '0;
      shifted_out   <= '0;
      zero          <= 1'b1;
      overflow      <= 1'b0;
    end else begin
      shifted_value <= w_shifted;
      shifted_out   <= input_value[WIDTH-1:WIDTH-SHIFT];
      zero          <= w_zero;
      overflow      <= w_overflow;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_left.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_shift_left
// Description : Directed self-checking bench for shift_left (WIDTH=16, SHIFT=1).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_shift_left;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] input_value = 16'h0000;
  logic [15:0] shifted_value;
  logic [0:0]  shifted_out;
  logic        zero;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  shift_left #(.WIDTH(16), .SHIFT(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_value   (input_value),
    .shifted_value (shifted_value),
    .shifted_out   (shifted_out),
    .zero          (zero),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] e_sv,
                       input logic e_so, input logic e_z, input logic e_ov);
    vectors++;
    assert (shifted_value === e_sv) else begin
      miscompares++;
      $error("FAIL %s shifted_value: observed %h expected %h", tag, shifted_value, e_sv);
    end
    assert (shifted_out === e_so) else begin
      miscompares++;
      $error("FAIL %s shifted_out: observed %b expected %b", tag, shifted_out, e_so);
    end
    assert (zero === e_z) else begin
      miscompares++;
      $error("FAIL %s zero: observed %b expected %b", tag, zero, e_z);
    end
    assert (overflow === e_ov) else begin
      miscompares++;
      $error("FAIL %s overflow: observed %b expected %b", tag, overflow, e_ov);
    end
  endtask

  // Apply one operand across one rising edge, then sample 1 ns later.
  task automatic step(input logic r, input logic [15:0] v);
    rst = r;
    input_value = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b1, 16'h1111); check("reset1", 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h1111); check("reset2", 16'h0000, 1'b0, 1'b1, 1'b0);

    step(1'b0, 16'h0000); check("zero_in", 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h1111); check("h1111",   16'h2222, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h8001); check("h8001",   16'h0002, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h4000); check("h4000",   16'h8000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'hC000); check("hC000",   16'h8000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h8000); check("h8000",   16'h0000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 16'hFFFF); check("hFFFF",   16'hFFFE, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h7FFF); check("h7FFF",   16'hFFFE, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'hA5A5); check("hA5A5",   16'h4B4A, 1'b1, 1'b0, 1'b1);

    // Outputs must hold while the operand moves between edges.
    input_value = 16'h0000;
    #3;
    check("hold", 16'h4B4A, 1'b1, 1'b0, 1'b1);

    // Reset beats a data load on the same edge.
    step(1'b1, 16'hFFFF); check("rst_prio", 16'h0000, 1'b0, 1'b1, 1'b0);

    step(1'b0, 16'h0001); check("seq1",     16'h0002, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0002); check("seq2",     16'h0004, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0004); check("seq_rst",  16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0004); check("seq_post", 16'h0008, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
